// File: rtl/miniled_pkg.sv
// Shared definitions for the MiniLED serial link receiver.
// Holds default geometry, FSM state codes, LE pulse decode values and counter limits.
package miniled_pkg;

    localparam int unsigned DEF_WORD_W  = 16;
    localparam int unsigned DEF_CH_NUM  = 16;
    localparam int unsigned DEF_ROW_NUM = 4;
    localparam int unsigned DEF_FCNT_W  = 16;

    // FSM state codes
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_LATCH  = 2'd2;
    localparam logic [1:0] ST_DECODE = 2'd3;

    // DCLK edges counted while LE is high select the event type
    localparam logic [3:0] LE_DATA  = 4'd0;
    localparam logic [3:0] LE_VSYNC = 4'd2;

    localparam logic [3:0] LE_CNT_MAX  = 4'd15;
    localparam logic [5:0] BIT_CNT_MAX = 6'd63;

endpackage

// File: rtl/miniled_sdi_receiver_if.sv
// Link and result bundle of the MiniLED serial link receiver.
// master: drives the link pins (LE/DCLK/SDI/scan) and observes the decoded results.
// slave:  the receiver; samples the link pins and drives the decoded results.
interface miniled_sdi_receiver_if
    import miniled_pkg::*;
#(
    parameter int unsigned WORD_W  = DEF_WORD_W,
    parameter int unsigned CH_NUM  = DEF_CH_NUM,
    parameter int unsigned ROW_NUM = DEF_ROW_NUM,
    parameter int unsigned FCNT_W  = DEF_FCNT_W
);
    localparam int unsigned CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int unsigned ROW_W = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;

    logic               I_dclk;
    logic               I_sdi;
    logic               I_le;
    logic [ROW_NUM-1:0] I_scan;

    logic               O_word_valid;
    logic [WORD_W-1:0]  O_word;
    logic [CH_W-1:0]    O_ch_idx;
    logic [ROW_W-1:0]   O_row_idx;
    logic               O_frame_pulse;
    logic [FCNT_W-1:0]  O_frame_cnt;
    logic               O_cmd_valid;
    logic [3:0]         O_cmd_code;
    logic               O_bit_err;
    logic               O_scan_err;

    modport master (
        output I_dclk, I_sdi, I_le, I_scan,
        input  O_word_valid, O_word, O_ch_idx, O_row_idx, O_frame_pulse, O_frame_cnt,
        input  O_cmd_valid, O_cmd_code, O_bit_err, O_scan_err
    );

    modport slave (
        input  I_dclk, I_sdi, I_le, I_scan,
        output O_word_valid, O_word, O_ch_idx, O_row_idx, O_frame_pulse, O_frame_cnt,
        output O_cmd_valid, O_cmd_code, O_bit_err, O_scan_err
    );

endinterface

// File: rtl/miniled_sync_edge.sv
// Two-flop synchroniser plus one delay stage for edge detection.
// I_clk/I_rst : system clock, async active-high reset
// I_async     : asynchronous input vector
// O_sync      : synchronised level
// O_rise      : 1-cycle pulse per bit on a synchronised 0->1 transition
// O_fall      : 1-cycle pulse per bit on a synchronised 1->0 transition
module miniled_sync_edge #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic [WIDTH-1:0] I_async,
    output logic [WIDTH-1:0] O_sync,
    output logic [WIDTH-1:0] O_rise,
    output logic [WIDTH-1:0] O_fall
);
    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] dly_q, dly_d;

    always_comb begin
        meta_d = I_async;
        sync_d = meta_q;
        dly_d  = sync_q;
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            meta_q <= '0;
            sync_q <= '0;
            dly_q  <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign O_sync = sync_q;
    assign O_rise = sync_q & ~dly_q;
    assign O_fall = ~sync_q & dly_q;

endmodule

// File: rtl/miniled_sdi_receiver.sv
// Receiving end of the LE/DCLK/SDI/scan MiniLED link, oversampled on I_clk.
// Deserialises SDI into grey words and decodes each LE pulse by the number of DCLK
// edges seen while LE was high: 0 = data latch, 2 = frame sync, other = command.
// I_clk/I_rst : system clock, async active-high reset
// link        : slave side of miniled_sdi_receiver_if (link pins in, decoded results out)
module miniled_sdi_receiver
    import miniled_pkg::*;
#(
    parameter int unsigned WORD_W  = DEF_WORD_W,
    parameter int unsigned CH_NUM  = DEF_CH_NUM,
    parameter int unsigned ROW_NUM = DEF_ROW_NUM,
    parameter int unsigned FCNT_W  = DEF_FCNT_W
) (
    input logic                   I_clk,
    input logic                   I_rst,
    miniled_sdi_receiver_if.slave link
);
    localparam int unsigned CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int unsigned ROW_W = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
    localparam logic [ROW_NUM-1:0] SCAN_ONE = ROW_NUM'(1);

    logic               dclk_rise, le_s, le_rise, le_fall, le_hi, sdi_s;
    logic [ROW_NUM-1:0] scan_s;
    logic               unused_dclk_s, unused_dclk_fall, unused_le_x;
    logic               unused_sdi_rise, unused_sdi_fall;
    logic [ROW_NUM-1:0] unused_scan_rise, unused_scan_fall;

    miniled_sync_edge #(.WIDTH(1)) u_sync_dclk (
        .I_clk(I_clk), .I_rst(I_rst), .I_async(link.I_dclk),
        .O_sync(unused_dclk_s), .O_rise(dclk_rise), .O_fall(unused_dclk_fall)
    );
    miniled_sync_edge #(.WIDTH(1)) u_sync_le (
        .I_clk(I_clk), .I_rst(I_rst), .I_async(link.I_le),
        .O_sync(le_s), .O_rise(le_rise), .O_fall(le_fall)
    );
    miniled_sync_edge #(.WIDTH(1)) u_sync_sdi (
        .I_clk(I_clk), .I_rst(I_rst), .I_async(link.I_sdi),
        .O_sync(sdi_s), .O_rise(unused_sdi_rise), .O_fall(unused_sdi_fall)
    );
    miniled_sync_edge #(.WIDTH(ROW_NUM)) u_sync_scan (
        .I_clk(I_clk), .I_rst(I_rst), .I_async(link.I_scan),
        .O_sync(scan_s), .O_rise(unused_scan_rise), .O_fall(unused_scan_fall)
    );
    assign unused_le_x = le_rise;

    // The cycle LE falls still counts as LE high, so a coinciding DCLK edge goes to le_cnt.
    assign le_hi = le_s | le_fall;

    logic [ROW_W-1:0] row_enc;
    logic             scan_multi;

    always_comb begin
        row_enc = '0;
        for (int i = ROW_NUM - 1; i >= 0; i--) begin
            if (scan_s[i]) row_enc = ROW_W'(i);
        end
    end
    // Clearing the lowest set bit leaves something only if more than one line is active.
    assign scan_multi = |(scan_s & (scan_s - SCAN_ONE));

    logic [1:0]        state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]        le_cnt_q, le_cnt_d;
    logic [CH_W-1:0]   ch_idx_q, ch_idx_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic              word_valid_q, word_valid_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [CH_W-1:0]   ch_out_q, ch_out_d;
    logic [ROW_W-1:0]  row_out_q, row_out_d;
    logic              frame_pulse_q, frame_pulse_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [3:0]        cmd_code_q, cmd_code_d;
    logic              bit_err_q, bit_err_d;
    logic              scan_err_q, scan_err_d;

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        le_cnt_d      = le_cnt_q;
        ch_idx_d      = ch_idx_q;
        frame_cnt_d   = frame_cnt_q;
        word_valid_d  = 1'b0;
        frame_pulse_d = 1'b0;
        cmd_valid_d   = 1'b0;
        word_d        = word_q;
        ch_out_d      = ch_out_q;
        row_out_d     = row_out_q;
        cmd_code_d    = cmd_code_q;
        bit_err_d     = bit_err_q;
        scan_err_d    = scan_err_q;

        if (dclk_rise) begin
            if (le_hi) begin
                if (le_cnt_q != LE_CNT_MAX) le_cnt_d = le_cnt_q + 4'd1;
            end else begin
                shift_d = {shift_q[WORD_W-2:0], sdi_s};
                if (bit_cnt_q != BIT_CNT_MAX) bit_cnt_d = bit_cnt_q + 6'd1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (le_rise)                 state_d = ST_LATCH;
                else if (dclk_rise && !le_hi) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (le_rise) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                if (le_fall) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                le_cnt_d  = '0;
                if (le_cnt_q == LE_DATA) begin
                    word_valid_d = 1'b1;
                    word_d       = shift_q;
                    ch_out_d     = ch_idx_q;
                    row_out_d    = row_enc;
                    ch_idx_d     = (ch_idx_q == CH_W'(CH_NUM - 1)) ? '0 : ch_idx_q + CH_W'(1);
                    if (bit_cnt_q != 6'(WORD_W)) bit_err_d = 1'b1;
                    if (scan_multi)              scan_err_d = 1'b1;
                end else if (le_cnt_q == LE_VSYNC) begin
                    frame_pulse_d = 1'b1;
                    frame_cnt_d   = frame_cnt_q + FCNT_W'(1);
                    ch_idx_d      = '0;
                end else begin
                    cmd_valid_d = 1'b1;
                    cmd_code_d  = le_cnt_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            le_cnt_q      <= '0;
            ch_idx_q      <= '0;
            frame_cnt_q   <= '0;
            word_valid_q  <= 1'b0;
            word_q        <= '0;
            ch_out_q      <= '0;
            row_out_q     <= '0;
            frame_pulse_q <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_code_q    <= '0;
            bit_err_q     <= 1'b0;
            scan_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            le_cnt_q      <= le_cnt_d;
            ch_idx_q      <= ch_idx_d;
            frame_cnt_q   <= frame_cnt_d;
            word_valid_q  <= word_valid_d;
            word_q        <= word_d;
            ch_out_q      <= ch_out_d;
            row_out_q     <= row_out_d;
            frame_pulse_q <= frame_pulse_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_code_q    <= cmd_code_d;
            bit_err_q     <= bit_err_d;
            scan_err_q    <= scan_err_d;
        end
    end

    assign link.O_word_valid  = word_valid_q;
    assign link.O_word        = word_q;
    assign link.O_ch_idx      = ch_out_q;
    assign link.O_row_idx     = row_out_q;
    assign link.O_frame_pulse = frame_pulse_q;
    assign link.O_frame_cnt   = frame_cnt_q;
    assign link.O_cmd_valid   = cmd_valid_q;
    assign link.O_cmd_code    = cmd_code_q;
    assign link.O_bit_err     = bit_err_q;
    assign link.O_scan_err    = scan_err_q;

endmodule
